// File: rtl/instr_scan_ctrl.sv
// instr_scan_ctrl
//
// Walks the instruction memory from word address 0 and fetches one 32-bit
// MIPS word at a time through a strobe/valid read handshake. Each word is
// pre-classified as R/I/J and offered to the statistics datapath through a
// valid/ready handshake. A scan ends in one of three ways:
//   - after the word at address NUM_INSTR-1 has been accepted;
//   - when HALT_WORD is read (the halt word is neither issued nor counted);
//   - on a memory timeout, if SCAN_TIMEOUT_EN is defined.
//
// Build option:
//   SCAN_TIMEOUT_EN  when defined, a WAIT that sees no mem_valid for 15
//                    consecutive cycles sets err_timeout and ends the scan.
//                    When undefined, WAIT waits forever and err_timeout is 0.
//
// Ports:
//   clk          clock; everything happens on the rising edge
//   rstn         synchronous, active-low reset
//   start        begin a scan; only looked at in IDLE
//   mem_rd       one-cycle read strobe (FETCH)
//   mem_addr     word address that goes with mem_rd
//   mem_valid    read data valid; only looked at in WAIT
//   mem_rdata    read data
//   cls_valid    instruction offered to the datapath (ISSUE)
//   cls_ready    datapath accepts the offered instruction
//   cls_instr    offered instruction word
//   cls_type     2'b00 R (opcode 0), 2'b01 J (opcode 2/3), 2'b10 I (others)
//   busy         high in every state except IDLE
//   done         sticky end-of-scan flag, cleared when start is accepted
//   instr_count  instructions accepted by the datapath in this run
//   err_timeout  sticky memory-timeout flag
module instr_scan_ctrl #(
  parameter int          ADDR_W    = 5,
  parameter int          NUM_INSTR = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              cls_valid,
  input  logic              cls_ready,
  output logic [31:0]       cls_instr,
  output logic [1:0]        cls_type,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   instr_count,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(NUM_INSTR - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              xfer;
  logic              rd_halt;
  logic              tmo_hit;

  function automatic logic [1:0] classify(input logic [5:0] op);
    if (op == 6'd0) begin
      return 2'b00;
    end else if (op == 6'd2 || op == 6'd3) begin
      return 2'b01;
    end else begin
      return 2'b10;
    end
  endfunction

  assign xfer    = (state == ISSUE) && cls_ready;
  assign rd_halt = (mem_rdata == HALT_WORD);

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    cls_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = pc;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          state_nxt = rd_halt ? DONE : ISSUE;
        end else if (tmo_hit) begin
          state_nxt = DONE;
        end
      end
      ISSUE: begin
        cls_valid = 1'b1;
        if (cls_ready) state_nxt = (pc == LAST_PC) ? DONE : FETCH;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
      cls_instr   <= '0;
      cls_type    <= 2'b00;
      done        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        pc          <= '0;
        instr_count <= '0;
        done        <= 1'b0;
      end
      // The offer registers load once per fetched word and then stay put
      // for the whole ISSUE, however long the datapath stalls.
      if (state == WAIT && mem_valid && !rd_halt) begin
        cls_instr <= mem_rdata;
        cls_type  <= classify(mem_rdata[31:26]);
      end
      if (xfer) begin
        instr_count <= instr_count + (ADDR_W + 1)'(1);
        // Holding pc at the last address keeps it from wrapping when
        // NUM_INSTR fills the whole address space.
        if (pc != LAST_PC) pc <= pc + ADDR_W'(1);
      end
      if (state == DONE) done <= 1'b1;
    end
  end

`ifdef SCAN_TIMEOUT_EN
  logic [3:0] tmo_cnt;

  // tmo_cnt is 0 on the first WAIT cycle, so a value of 14 marks the
  // 15th consecutive cycle without mem_valid.
  assign tmo_hit = (state == WAIT) && !mem_valid && (tmo_cnt == 4'd14);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt     <= 4'd0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && start) err_timeout <= 1'b0;
      if (state == FETCH) begin
        tmo_cnt <= 4'd0;
      end else if (state == WAIT && !mem_valid && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 4'd1;
      end
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/instr_scan_ctrl.md
# instr_scan_ctrl

Sequencer that walks an instruction memory from address 0, fetches each 32-bit MIPS word through a request/valid handshake, pre-classifies it as R/I/J and hands it to the instruction-statistics datapath through a valid/ready handshake. It sits between the instruction ROM and the type/destination-register counters. It owns program-counter stepping, start/done control and scan termination.

## Interface
- ADDR_W, 5, word-address width of instruction memory
- NUM_INSTR, 8, maximum words scanned per run (1..2^ADDR_W)
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates the scan early

- clk  in  1  clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  ADDR_W  word address accompanying mem_rd
- mem_valid  in  1  read data valid; ignored outside WAIT
- mem_rdata  in  32  read data
- cls_valid  out  1  instruction offered to datapath
- cls_ready  in  1  datapath accepts
- cls_instr  out  32  offered instruction word
- cls_type  out  2  2'b00 R (opcode 0), 2'b01 J (opcode 2 or 3), 2'b10 I (all other opcodes)
- busy  out  1  high in every state except IDLE
- done  out  1  sticky; set on scan end, cleared when start is accepted
- instr_count  out  ADDR_W+1  instructions accepted by datapath this run
- err_timeout  out  1  sticky memory-timeout flag (see Configuration)

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, DONE.
- Reset (rstn=0 at an edge): state IDLE. pc, instr_count, mem_rd, mem_addr, cls_valid, cls_instr, cls_type, busy, done and err_timeout all 0. Reset mid-scan aborts with no handshake completion.
- IDLE: start=1 -> pc<=0, instr_count<=0, done<=0, err_timeout<=0, go FETCH.
- start outside IDLE is ignored.
- FETCH: mem_rd=1, mem_addr=pc for exactly this cycle -> WAIT.
- WAIT: on mem_valid, register mem_rdata.
  - If the word equals HALT_WORD -> DONE. The halt word is not issued or counted.
  - Otherwise -> ISSUE, with cls_type computed from bits [31:26].
- ISSUE: cls_valid=1. cls_instr and cls_type are held stable until cls_valid&&cls_ready.
  - On the transfer: instr_count+1, pc+1.
  - If the accepted pc equals NUM_INSTR-1 -> DONE, else -> FETCH.
- DONE: done<=1 -> IDLE next cycle. done stays high in IDLE until the next accepted start.
- pc never wraps. The last address scanned is NUM_INSTR-1.

## Timing
- mem_rd is asserted the cycle after start is sampled.
- Minimum mem_valid is the cycle after mem_rd. The earliest cls_valid is the cycle after mem_valid.
- Zero-wait memory with cls_ready tied high gives 3 cycles per instruction. A full run takes 3*NUM_INSTR+1 cycles from start to the done rising edge.
- cls_valid never drops without a transfer, except on reset.
- mem_valid arriving in the same cycle as mem_rd is not accepted. The bench must not drive it.

## Configuration
- SCAN_TIMEOUT_EN defined:
  - A 4-bit counter runs in WAIT and clears on entry to WAIT.
  - If 15 consecutive WAIT cycles pass without mem_valid: err_timeout<=1, go DONE. instr_count keeps the words already accepted.
- SCAN_TIMEOUT_EN undefined: WAIT waits indefinitely, and err_timeout is tied to 0.

## Test plan
- NUM_INSTR=8, ROM holds 3 R, 2 J, 3 I, zero-wait memory, cls_ready=1 -> cls_type sequence matches ROM order; instr_count=8; done rises 25 cycles after start.
- Same ROM with cls_ready low for 4 cycles during word 2 -> cls_instr held stable; no extra mem_rd issued; final instr_count=8.
- HALT_WORD at address 5 -> exactly 5 transfers, instr_count=5, done=1, no mem_rd to address 6.
- rstn low for one cycle during the ISSUE of word 3 -> next cycle all outputs 0 and state IDLE; a new start rescans from address 0.
- start pulsed while busy -> ignored, with no pc reset. start in IDLE after done -> done clears the next cycle.
- SCAN_TIMEOUT_EN defined and mem_valid withheld for word 4 -> err_timeout=1 after 15 WAIT cycles, instr_count=4, done=1. With the macro undefined, the block stays busy and err_timeout=0.
